cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the common data bus (CDB) lanes between the functional-unit/reservation-station result producers.
//  Each cycle it grants up to NUM_LANES pending results, round-robin, and drives them one cycle later
//  as registered broadcasts (valid, dest_rob, value) to the ROB, the reservation stations and the regfile.
//  It guarantees bounded wait for every producer and supports a synchronous flush on mispredict.
// PARAMETERS
//  NUM_REQ    8   number of result producers (requesters), >= 1
//  NUM_LANES  5   number of CDB broadcast lanes, 1..NUM_REQ
//  ROB_IDX_W  5   ROB index width (32-entry ROB)
//  DATA_W     32  result value width
// PORTS
//  clk             in   1                    clock, all state on rising edge
//  rst             in   1                    asynchronous, active-low reset (0 = reset)
//  flush           in   1                    synchronous pipeline flush
//  req_valid       in   NUM_REQ              producer i has a result pending
//  req_dest_rob    in   NUM_REQ*ROB_IDX_W    ROB index of producer i's result
//  req_value       in   NUM_REQ*DATA_W       result value of producer i
//  req_ready       out  NUM_REQ              producer i granted this cycle (combinational)
//  bus_valid       out  NUM_LANES            lane k carries a broadcast (registered)
//  bus_dest_rob    out  NUM_LANES*ROB_IDX_W  lane k ROB index (registered)
//  bus_value       out  NUM_LANES*DATA_W     lane k value (registered)
//  conflict_cnt    out  16                   cycles in which >= 1 valid request was not granted
// BEHAVIOUR
//  - Reset (rst=0, async): bus_valid=0, bus_dest_rob=0, bus_value=0, rr_ptr=0, conflict_cnt=0.
//    req_ready=0 while rst=0. The first grant is possible on the first edge after rst deasserts.
//  - Handshake: a transfer happens when req_valid[i] && req_ready[i]. The producer holds valid, dest_rob
//    and value stable until it sees ready. req_ready never asserts without req_valid.
//  - Grant: scan requesters in order rr_ptr, rr_ptr+1, ... (mod NUM_REQ). Grant the first NUM_LANES valid ones.
//    The j-th grant in scan order maps to lane j. Grant is combinational from req_valid and rr_ptr.
//  - Latency: a granted result appears on its lane exactly 1 cycle after the grant cycle.
//    Lanes without a grant drive valid=0, dest_rob=0, value=0. Each lane holds its broadcast for 1 cycle only.
//  - rr_ptr: if any grant, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
//    With no grants, rr_ptr is unchanged. Wrap-around is handled by the modulo, with no dead cycle.
//  - Fairness: a continuously valid request is granted within ceil(NUM_REQ/NUM_LANES) cycles.
//    When valid count <= NUM_LANES, all valid requests are granted that cycle.
//  - flush=1 has priority over grants:
//    - req_ready=0 that cycle.
//    - Next cycle: bus_valid=0, rr_ptr=0.
//    - The broadcast already registered in the flush cycle is still driven that cycle; its consumers discard it.
//  - conflict_cnt: +1 on each non-flush cycle with (valid count > NUM_LANES). Saturates at 16'hFFFF.
//    It is not cleared by flush, only by reset.
//  - No dest_rob uniqueness check. Duplicates are broadcast on separate lanes as presented.
// TESTING
//  1 rst=0 for 5 cycles, then release, no requests -> bus_valid=0, req_ready=0, conflict_cnt=0 throughout.
//  2 req_valid=8'b0000_0100, dest_rob[2]=8, value[2]=156 -> req_ready[2]=1 same cycle;
//    next cycle bus_valid=5'b00001, lane0={8,156}; rr_ptr=3.
//  3 all 8 valid, held until granted, rr_ptr=0 -> cycle0 grants 0-4 on lanes 0-4,
//    cycle1 grants 5,6,7 on lanes 0-2 with rr_ptr=0 after; conflict_cnt=1.
//  4 rr_ptr=6, valid={0,1,6,7} -> scan order 6,7,0,1: lanes 0-3 = producers 6,7,0,1; rr_ptr becomes 2.
//  5 all valid plus flush=1 -> req_ready=0; next cycle bus_valid=0, rr_ptr=0; conflict_cnt unchanged.
//  6 rst=0 asserted mid-burst while bus_valid=5'b11111 -> outputs clear immediately (async), not at the next edge;
//    after release, pending producers are granted starting from index 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of up to NUM_LANES result producers per cycle onto registered CDB lanes.
// Grants are combinational; the granted results are broadcast on the following cycle.
module cdb_arbiter #(
    parameter int NUM_REQ   = 8,
    parameter int NUM_LANES = 5,
    parameter int ROB_IDX_W = 5,
    parameter int DATA_W    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_dest_rob,
    input  logic [NUM_REQ*DATA_W-1:0]      req_value,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_LANES-1:0]           bus_valid,
    output logic [NUM_LANES*ROB_IDX_W-1:0] bus_dest_rob,
    output logic [NUM_LANES*DATA_W-1:0]    bus_value,
    output logic [15:0]                    conflict_cnt
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(NUM_LANES + 1);

    logic [PW-1:0]                            rr_ptr_q, rr_ptr_d, last;
    logic [CW-1:0]                            n;
    logic [NUM_REQ-1:0]                       grant;
    logic                                     conflict;
    logic [NUM_LANES-1:0]                     lv_d, lv_q;
    logic [NUM_LANES-1:0][ROB_IDX_W-1:0]      lr_d, lr_q;
    logic [NUM_LANES-1:0][DATA_W-1:0]         ld_d, ld_q;
    logic [15:0]                              cnt_q, cnt_d;

    // Two passes over the requesters: first those at or after rr_ptr, then the wrapped ones below it.
    always_comb begin
        grant = '0;
        n     = '0;
        last  = '0;
        lv_d  = '0;
        lr_d  = '0;
        ld_d  = '0;
        for (int k = 0; k < 2 * NUM_REQ; k++) begin
            if (rst && !flush && req_valid[k % NUM_REQ] && n < CW'(NUM_LANES) &&
                ((k < NUM_REQ) == (PW'(k % NUM_REQ) >= rr_ptr_q))) begin
                grant[k % NUM_REQ] = 1'b1;
                for (int j = 0; j < NUM_LANES; j++) begin
                    if (n == CW'(j)) begin
                        lv_d[j] = 1'b1;
                        lr_d[j] = req_dest_rob[(k % NUM_REQ) * ROB_IDX_W +: ROB_IDX_W];
                        ld_d[j] = req_value[(k % NUM_REQ) * DATA_W +: DATA_W];
                    end
                end
                last = PW'(k % NUM_REQ);
                n    = n + CW'(1);
            end
        end
        conflict = !flush && |(req_valid & ~grant);
        rr_ptr_d = flush ? '0 : !(|grant) ? rr_ptr_q : last == PW'(NUM_REQ - 1) ? '0 : last + PW'(1);
        cnt_d    = (conflict && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            lv_q     <= '0;
            lr_q     <= '0;
            ld_q     <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            lv_q     <= lv_d;
            lr_q     <= lr_d;
            ld_q     <= ld_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready    = grant;
    assign bus_valid    = lv_q;
    assign bus_dest_rob = lr_q;
    assign bus_value    = ld_q;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: vector table plus scoreboard of expected lane broadcasts for cdb_arbiter.
module tb_cdb_arbiter;
    localparam int N = 15;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic [7:0]   req_valid = '0;
    logic [39:0]  req_dest_rob;
    logic [255:0] req_value;
    logic [7:0]   req_ready;
    logic [4:0]   bus_valid;
    logic [24:0]  bus_dest_rob;
    logic [159:0] bus_value;
    logic [15:0]  conflict_cnt;

    int asserts = 0;
    int fails   = 0;
    int rob_t[8] = '{3, 17, 8, 30, 12, 25, 6, 21};

    typedef struct {
        logic [4:0]   v;
        logic [24:0]  r;
        logic [159:0] d;
    } bus_t;

    typedef struct {
        logic [7:0]  v;
        logic        f;
        logic [7:0]  rdy;
        logic [19:0] ln;
        logic [15:0] cnt;
    } vec_t;

    vec_t tv[14];
    bus_t sb[$];
    bus_t e;

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_dest_rob(req_dest_rob), .req_value(req_value),
        .req_ready(req_ready), .bus_valid(bus_valid), .bus_dest_rob(bus_dest_rob),
        .bus_value(bus_value), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] val_of(input int p);
        return p == 2 ? 32'd156 : 32'hC0DE_0000 + 32'(p * 77);
    endfunction

    function automatic logic [19:0] mk(input int a, input int b, input int c, input int d, input int x);
        return {4'(x), 4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic bus_t exp_bus(input logic [19:0] l);
        bus_t b;
        int p;
        b.v = '0;
        b.r = '0;
        b.d = '0;
        for (int j = 0; j < 5; j++) begin
            p = int'(l[j*4 +: 4]);
            if (p != N) begin
                b.v[j] = 1'b1;
                b.r[j*5 +: 5] = 5'(rob_t[p]);
                b.d[j*32 +: 32] = val_of(p);
            end
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] cnt);
        bus_t b;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 160'd1, 160'd0);
        end else begin
            b = sb.pop_front();
            chk({tag, " bus_valid"}, 160'(bus_valid), 160'(b.v));
            chk({tag, " bus_dest_rob"}, 160'(bus_dest_rob), 160'(b.r));
            chk({tag, " bus_value"}, bus_value, b.d);
        end
        chk({tag, " conflict_cnt"}, 160'(conflict_cnt), 160'(cnt));
    endtask

    initial begin
        tv[0]  = '{8'h00, 1'b0, 8'h00, mk(N, N, N, N, N), 16'd0};
        tv[1]  = '{8'h04, 1'b0, 8'h04, mk(2, N, N, N, N), 16'd0};
        tv[2]  = '{8'h00, 1'b1, 8'h00, mk(N, N, N, N, N), 16'd0};
        tv[3]  = '{8'hFF, 1'b0, 8'h1F, mk(0, 1, 2, 3, 4), 16'd1};
        tv[4]  = '{8'hE0, 1'b0, 8'hE0, mk(5, 6, 7, N, N), 16'd1};
        tv[5]  = '{8'h20, 1'b0, 8'h20, mk(5, N, N, N, N), 16'd1};
        tv[6]  = '{8'hC3, 1'b0, 8'hC3, mk(6, 7, 0, 1, N), 16'd1};
        tv[7]  = '{8'h03, 1'b0, 8'h03, mk(0, 1, N, N, N), 16'd1};
        tv[8]  = '{8'hFF, 1'b0, 8'h7C, mk(2, 3, 4, 5, 6), 16'd2};
        tv[9]  = '{8'hFF, 1'b0, 8'h8F, mk(7, 0, 1, 2, 3), 16'd3};
        tv[10] = '{8'hFF, 1'b1, 8'h00, mk(N, N, N, N, N), 16'd3};
        tv[11] = '{8'h01, 1'b0, 8'h01, mk(0, N, N, N, N), 16'd3};
        tv[12] = '{8'h81, 1'b0, 8'h81, mk(7, 0, N, N, N), 16'd3};
        tv[13] = '{8'h00, 1'b0, 8'h00, mk(N, N, N, N, N), 16'd3};
        for (int i = 0; i < 8; i++) begin
            req_dest_rob[i*5 +: 5] = 5'(rob_t[i]);
            req_value[i*32 +: 32]  = val_of(i);
        end

        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("reset bus_valid", 160'(bus_valid), 160'd0);
            chk("reset req_ready", 160'(req_ready), 160'd0);
            chk("reset conflict_cnt", 160'(conflict_cnt), 160'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle bus_valid", 160'(bus_valid), 160'd0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req_valid = tv[i].v;
            flush     = tv[i].f;
            sb.push_back(exp_bus(tv[i].ln));
            #1;
            chk($sformatf("vec%0d req_ready", i), 160'(req_ready), 160'(tv[i].rdy));
            @(posedge clk);
            #1;
            pop_chk($sformatf("vec%0d", i), tv[i].cnt);
        end

        // async reset in the middle of a full-lane burst
        @(negedge clk);
        req_valid = 8'hFF;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        chk("burst bus_valid", 160'(bus_valid), 160'h1F);
        #2;
        rst = 1'b0;
        #1;
        chk("async bus_valid", 160'(bus_valid), 160'd0);
        chk("async bus_value", bus_value, 160'd0);
        chk("async req_ready", 160'(req_ready), 160'd0);
        chk("async conflict_cnt", 160'(conflict_cnt), 160'd0);
        @(negedge clk);
        rst = 1'b1;
        sb.push_back(exp_bus(mk(0, 1, 2, 3, 4)));
        #1;
        chk("post-reset req_ready", 160'(req_ready), 160'h1F);
        @(posedge clk);
        #1;
        pop_chk("post-reset", 16'd1);
        @(negedge clk);
        req_valid = 8'h00;

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
